// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - FIFO read-side drain controller presenting a valid/ready stream
// Optional delivered-word counter enabled by defining FIFO_RD_STREAM_CNT_EN.
module fifo_rd_stream #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             fifo_empty_i,
   input  logic [WIDTH-1:0] fifo_data_i,
   output logic             fifo_rd_en_o,
   output logic             m_valid_o,
   output logic [WIDTH-1:0] m_data_o,
   input  logic             m_ready_i,
   output logic             busy_o,
   output logic [CNT_W-1:0] words_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] mem_q [2];
   logic             head_q;
   logic             tail_q;
   logic [1:0]       count_q;
   logic [1:0]       count_d;
   logic             inflight_q;
   logic [1:0]       occ;
   logic             xfer;
   logic             rd_en;

   assign occ  = count_q + {1'b0, inflight_q};
   assign xfer = m_valid_o && m_ready_i;

   // A pop at occupancy 2 is only safe when the head leaves in the same cycle.
   assign rd_en = (state_q == RUN) && en_i && !fifo_empty_i &&
                  ((occ < 2'd2) || ((occ == 2'd2) && xfer));

   assign count_d = count_q + {1'b0, inflight_q} - {1'b0, xfer};

   assign fifo_rd_en_o = rd_en;
   assign m_valid_o    = (count_q != 2'd0);
   assign m_data_o     = mem_q[head_q];
   assign busy_o       = (state_q != IDLE) || (count_q != 2'd0) || inflight_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (en_i) state_d = RUN;
         end
         RUN: begin
            if (!en_i) state_d = DRAIN;
         end
         DRAIN: begin
            if (en_i) begin
               state_d = RUN;
            end else if ((count_q == 2'd0) && !inflight_q) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         count_q    <= 2'd0;
         inflight_q <= 1'b0;
         head_q     <= 1'b0;
         tail_q     <= 1'b0;
         mem_q[0]   <= '0;
         mem_q[1]   <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         inflight_q <= rd_en;
         // The word popped last cycle is on fifo_data_i now.
         if (inflight_q) begin
            mem_q[tail_q] <= fifo_data_i;
            tail_q        <= ~tail_q;
         end
         if (xfer) begin
            head_q <= ~head_q;
         end
      end
   end

`ifdef FIFO_RD_STREAM_CNT_EN
   logic [CNT_W-1:0] words_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         words_q <= '0;
      end else if (xfer) begin
         words_q <= words_q + 1'b1;
      end
   end

   assign words_o = words_q;
`else
   assign words_o = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - directed self-checking bench for fifo_rd_stream
// Counter expectations follow FIFO_RD_STREAM_CNT_EN.
module tb_fifo_rd_stream;

   localparam int WIDTH = 32;
   localparam int CNT_W = 4;
`ifdef FIFO_RD_STREAM_CNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic             clk_i = 1'b0;
   logic             rst_i = 1'b1;
   logic             en_i = 1'b0;
   logic             fifo_empty_i;
   logic [WIDTH-1:0] fifo_data_i = '0;
   logic             fifo_rd_en_o;
   logic             m_valid_o;
   logic [WIDTH-1:0] m_data_o;
   logic             m_ready_i = 1'b0;
   logic             busy_o;
   logic [CNT_W-1:0] words_o;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural FIFO: registered read data, one-cycle latency.
   logic [WIDTH-1:0] fifo_mem [64];
   int               wr_ptr = 0;
   int               rd_ptr = 0;
   logic             force_empty = 1'b0;

   assign fifo_empty_i = force_empty || (wr_ptr == rd_ptr);

   always @(posedge clk_i) begin
      if (fifo_rd_en_o && (wr_ptr != rd_ptr)) begin
         fifo_data_i <= fifo_mem[rd_ptr];
         rd_ptr      <= rd_ptr + 1;
      end
   end

   always #5 clk_i = ~clk_i;

   fifo_rd_stream #(
      .WIDTH(WIDTH),
      .CNT_W(CNT_W)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .en_i        (en_i),
      .fifo_empty_i(fifo_empty_i),
      .fifo_data_i (fifo_data_i),
      .fifo_rd_en_o(fifo_rd_en_o),
      .m_valid_o   (m_valid_o),
      .m_data_o    (m_data_o),
      .m_ready_i   (m_ready_i),
      .busy_o      (busy_o),
      .words_o     (words_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push(input logic [WIDTH-1:0] d);
      fifo_mem[wr_ptr] = d;
      wr_ptr = wr_ptr + 1;
   endtask

   function automatic logic [31:0] exp_words(input int n);
      return CNT_ON ? 32'(n % 16) : 32'd0;
   endfunction

   initial begin
      logic [5:0]  exp_rd;
      logic [5:0]  exp_vld;
      logic [31:0] exp_dat [6];
      int          pops;

      // Reset
      tick();
      tick();
      rst_i = 1'b0;
      #1;
      check("rst_valid", 32'(m_valid_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_rden", 32'(fifo_rd_en_o), 32'd0);
      check("rst_data", m_data_o, 32'd0);
      check("rst_words", 32'(words_o), 32'd0);

      // Three words, downstream always ready
      push(32'hA1);
      push(32'hA2);
      push(32'hA3);
      m_ready_i = 1'b1;
      en_i      = 1'b1;
      exp_rd    = 6'b000111;
      exp_vld   = 6'b011100;
      exp_dat[2] = 32'hA1;
      exp_dat[3] = 32'hA2;
      exp_dat[4] = 32'hA3;
      for (int i = 0; i < 6; i++) begin
         tick();
         check($sformatf("t1_rden%0d", i), 32'(fifo_rd_en_o), 32'(exp_rd[i]));
         check($sformatf("t1_valid%0d", i), 32'(m_valid_o), 32'(exp_vld[i]));
         if (exp_vld[i]) check($sformatf("t1_data%0d", i), m_data_o, exp_dat[i]);
      end
      check("t1_words", 32'(words_o), exp_words(3));
      en_i = 1'b0;
      tick();
      tick();
      check("t1_idle_busy", 32'(busy_o), 32'd0);

      // Back-pressure: five words queued, ready low
      m_ready_i = 1'b0;
      for (int i = 1; i <= 5; i++) push(32'hB0 + 32'(i));
      en_i = 1'b1;
      pops = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (fifo_rd_en_o) pops++;
      end
      check("t2_pops", 32'(pops), 32'd2);
      check("t2_rden_stop", 32'(fifo_rd_en_o), 32'd0);
      check("t2_valid_hold", 32'(m_valid_o), 32'd1);
      check("t2_data_hold", m_data_o, 32'hB1);
      m_ready_i = 1'b1;
      #1;
      for (int i = 1; i <= 5; i++) begin
         check($sformatf("t2_valid%0d", i), 32'(m_valid_o), 32'd1);
         check($sformatf("t2_data%0d", i), m_data_o, 32'hB0 + 32'(i));
         tick();
      end
      check("t2_valid_end", 32'(m_valid_o), 32'd0);
      check("t2_words", 32'(words_o), exp_words(8));
      en_i = 1'b0;
      tick();
      tick();

      // Empty FIFO while running
      force_empty = 1'b1;
      en_i        = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t3_rden%0d", i), 32'(fifo_rd_en_o), 32'd0);
         check($sformatf("t3_valid%0d", i), 32'(m_valid_o), 32'd0);
         check($sformatf("t3_busy%0d", i), 32'(busy_o), 32'd1);
         tick();
      end
      en_i        = 1'b0;
      force_empty = 1'b0;
      tick();
      tick();
      check("t3_idle_busy", 32'(busy_o), 32'd0);

      // en_i dropped the cycle after a pop
      push(32'hC1);
      push(32'hC2);
      push(32'hC3);
      en_i = 1'b1;
      tick();
      check("t4_rden_first", 32'(fifo_rd_en_o), 32'd1);
      tick();
      en_i = 1'b0;
      #1;
      check("t4_rden_gated", 32'(fifo_rd_en_o), 32'd0);
      tick();
      check("t4_valid", 32'(m_valid_o), 32'd1);
      check("t4_data", m_data_o, 32'hC1);
      check("t4_rden_drain", 32'(fifo_rd_en_o), 32'd0);
      tick();
      check("t4_valid_gone", 32'(m_valid_o), 32'd0);
      check("t4_busy_drain", 32'(busy_o), 32'd1);
      check("t4_rden_drain2", 32'(fifo_rd_en_o), 32'd0);
      tick();
      check("t4_busy_idle", 32'(busy_o), 32'd0);
      check("t4_words", 32'(words_o), exp_words(9));

      // Reset with two words buffered (C2, C3 still in the FIFO)
      m_ready_i = 1'b0;
      en_i      = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      check("t5_valid_pre", 32'(m_valid_o), 32'd1);
      check("t5_data_pre", m_data_o, 32'hC2);
      rst_i = 1'b1;
      en_i  = 1'b0;
      tick();
      rst_i = 1'b0;
      #1;
      check("t5_valid", 32'(m_valid_o), 32'd0);
      check("t5_busy", 32'(busy_o), 32'd0);
      check("t5_words", 32'(words_o), 32'd0);
      check("t5_data", m_data_o, 32'd0);

      // Seventeen transfers wrap a 4-bit counter
      for (int i = 0; i < 17; i++) push(32'h100 + 32'(i));
      m_ready_i = 1'b1;
      en_i      = 1'b1;
      for (int j = 0; j < 20; j++) begin
         tick();
         check($sformatf("t6_rden%0d", j), 32'(fifo_rd_en_o), (j <= 16) ? 32'd1 : 32'd0);
         check($sformatf("t6_valid%0d", j), 32'(m_valid_o), (j >= 2 && j <= 18) ? 32'd1 : 32'd0);
         if (j >= 2 && j <= 18) check($sformatf("t6_data%0d", j), m_data_o, 32'h100 + 32'(j - 2));
      end
      en_i = 1'b0;
      tick();
      tick();
      check("t6_words", 32'(words_o), exp_words(17));
      check("t6_busy", 32'(busy_o), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
